seq_detector_param: RTL and testbench

Parametrised, runtime-programmable serial bit-sequence detector, successor to the fixed-pattern `Sequence_detector`. It samples one bit per qualified clock and pulses `out` whenever the most recent `pat_len` bits equal the loaded pattern. Overlapping or non-overlapping detection is selectable at runtime, and a saturating match counter is provided. It sits directly on a serial input stream, with its configuration driven by a control block.

---
 rtl/seq_det_pkg.sv | 32 +++
 rtl/seq_det_if.sv | 28 ++
 rtl/seq_det_hist.sv | 37 +++
 rtl/seq_detector_param.sv | 85 ++++++++
 tb/tb_seq_detector_param.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared widths, reset defaults and helpers for the programmable sequence detector.
package seq_det_pkg;

  // Widest pattern the mask helper can describe; callers slice down to PAT_W.
  localparam int MAX_W = 64;

  localparam logic [7:0] DFLT_PAT = 8'b0001_0101;
  localparam int         DFLT_LEN = 5;
  localparam bit         DFLT_OVL = 1'b1;

  function automatic int len_w(int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int clamp_len(int len, int max_len);
    if (len < 1)
      return 1;
    else if (len > max_len)
      return max_len;
    else
      return len;
  endfunction

  function automatic logic [MAX_W-1:0] len_mask(int len);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++)
      m[i] = (i < len);
    return m;
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Serial stream, configuration and status bundle for seq_detector_param.
interface seq_det_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = seq_det_pkg::len_w(PAT_W);

  logic             in;
  logic             in_valid;
  logic             load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic [LEN_W-1:0] state;

  modport master (
    output in, in_valid, load, pattern, pat_len, overlap,
    input  out, match_cnt, state
  );

  modport slave (
    input  in, in_valid, load, pattern, pat_len, overlap,
    output out, match_cnt, state
  );

endinterface

// File: rtl/seq_det_hist.sv
// Bit history shift register plus fill counter saturating at the active length.
// One-cycle update; no backpressure, the stream is accepted whenever shift_en is high.
module seq_det_hist #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             restart,
  input  logic             din,
  input  logic [LEN_W-1:0] len,
  output logic [PAT_W-1:0] hist,
  output logic [LEN_W-1:0] fill
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= {hist[PAT_W-2:0], din};
      // len is never zero, so len-1 cannot wrap
      if (restart)
        fill <= '0;
      else if (fill >= len - LEN_W'(1))
        fill <= len;
      else
        fill <= fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap select and saturating match count.
// out registers at the edge sampling the completing bit; no backpressure, bits gated only by in_valid.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DFLT_PAT),
  parameter int               DEF_LEN = DFLT_LEN,
  parameter bit               DEF_OVL = DFLT_OVL
) (
  input logic      clk,
  input logic      reset,
  seq_det_if.slave bus
);

  localparam int LEN_W = len_w(PAT_W);

  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] mask;
  logic [PAT_W:0]   diff;
  logic             accept;
  logic             full;
  logic             match;
  logic             out_q;
  logic [CNT_W-1:0] cnt_q;

  assign accept = bus.in_valid & ~bus.load;
  assign mask   = PAT_W'(len_mask(int'(cfg_len)));
  assign full   = (fill >= cfg_len - LEN_W'(1));
  // Compare against the history as it will be after this bit shifts in; the
  // bit falling off the top is always outside the mask.
  assign diff   = ({hist, bus.in} ^ {1'b0, cfg_pat}) & {1'b0, mask};
  assign match  = accept & full & (diff == '0);

  seq_det_hist #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .clear    (bus.load),
    .restart  (match & ~cfg_ovl),
    .din      (bus.in),
    .len      (cfg_len),
    .hist     (hist),
    .fill     (fill)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_pat <= DEF_PAT;
      cfg_len <= LEN_W'(clamp_len(DEF_LEN, PAT_W));
      cfg_ovl <= DEF_OVL;
    end else if (bus.load) begin
      cfg_pat <= bus.pattern;
      cfg_len <= LEN_W'(clamp_len(int'(bus.pat_len), PAT_W));
      cfg_ovl <= bus.overlap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else if (bus.load) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= match;
      if (match && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out       = out_q;
  assign bus.match_cnt = cnt_q;
  assign bus.state     = fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomized and directed bench for seq_detector_param; two DUTs share one stream (CNT_W 8 and 2).
module tb_seq_detector_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_det_if #(.PAT_W(8), .CNT_W(8)) b1 ();
  seq_det_if #(.PAT_W(8), .CNT_W(2)) b2 ();

  seq_detector_param dut1 (.clk(clk), .reset(rst_n), .bus(b1));
  seq_detector_param #(.CNT_W(2)) dut2 (.clk(clk), .reset(rst_n), .bus(b2));

  assign b2.in       = b1.in;
  assign b2.in_valid = b1.in_valid;
  assign b2.load     = b1.load;
  assign b2.pattern  = b1.pattern;
  assign b2.pat_len  = b1.pat_len;
  assign b2.overlap  = b1.overlap;

  always #5 clk = ~clk;

  // Reference: keep the accepted bits since the last restart and compare the
  // newest len of them against the pattern written out bit by bit.
  bit         q[$];
  logic [7:0] m_pat  = 8'h15;
  int         m_len  = 5;
  bit         m_ovl  = 1'b1;
  bit         m_out  = 1'b0;
  int         m_cnt8 = 0;
  int         m_cnt2 = 0;
  int         n_len;
  bit         hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_out = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
      m_pat = 8'h15; m_len = 5; m_ovl = 1'b1;
    end else if (b1.load) begin
      n_len = int'(b1.pat_len);
      if (n_len == 0) n_len = 1;
      if (n_len > 8) n_len = 8;
      m_pat = b1.pattern; m_len = n_len; m_ovl = b1.overlap;
      q.delete();
      m_out = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (b1.in_valid) begin
      q.push_back(b1.in);
      if (q.size() > m_len) void'(q.pop_front());
      hit = (q.size() == m_len);
      if (hit)
        for (int i = 0; i < m_len; i++)
          if (q[i] != m_pat[m_len-1-i]) hit = 1'b0;
      m_out = hit;
      if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!m_ovl) q.delete();
      end
    end else begin
      m_out = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out",        b1.out,       m_out);
    chk("match_cnt",  b1.match_cnt, m_cnt8);
    chk("state",      b1.state,     q.size());
    chk("out_c2",     b2.out,       m_out);
    chk("match_cnt2", b2.match_cnt, m_cnt2);
    chk("state_c2",   b2.state,     q.size());
  end

  task automatic shift(input logic b, input logic v);
    b1.in = b; b1.in_valid = v; b1.load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] n, input logic o);
    b1.load = 1'b1; b1.pattern = p; b1.pat_len = n; b1.overlap = o;
    b1.in_valid = 1'b1; b1.in = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    b1.load = 1'b0; b1.in_valid = 1'b0;
  endtask

  // bits and expected pulses are listed first-bit-first from the MSB of n bits
  task automatic run_bits(input string name, input logic [15:0] bits, input int n,
                          input logic [15:0] exp_out);
    for (int i = n - 1; i >= 0; i--) begin
      shift(bits[i], 1'b1);
      chk(name, b1.out, exp_out[i]);
    end
  endtask

  initial begin
    b1.in = 1'b0; b1.in_valid = 1'b0; b1.load = 1'b0;
    b1.pattern = '0; b1.pat_len = '0; b1.overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", b1.out, 0);
    chk("rst_cnt", b1.match_cnt, 0);
    chk("rst_state", b1.state, 0);
    rst_n = 1'b1;

    // defaults: 10101 overlapping
    run_bits("t1_out", 16'b1010101, 7, 16'b0000101);
    chk("t1_cnt", b1.match_cnt, 2);
    chk("t1_state", b1.state, 5);

    // non-overlapping
    do_load(8'h15, 4'd5, 1'b0);
    chk("t2_cnt_clr", b1.match_cnt, 0);
    chk("t2_state_clr", b1.state, 0);
    run_bits("t2_out", 16'b1010101, 7, 16'b0000100);
    chk("t2_cnt", b1.match_cnt, 1);
    chk("t2_state", b1.state, 2);

    // 110, with unloaded port changes ignored
    do_load(8'b110, 4'd3, 1'b1);
    b1.pattern = 8'hFF; b1.pat_len = 4'd8; b1.overlap = 1'b0;
    run_bits("t3_out", 16'b0110110, 7, 16'b0001001);
    chk("t3_cnt", b1.match_cnt, 2);

    // in_valid gap
    do_load(8'h15, 4'd5, 1'b1);
    run_bits("t4_pre", 16'b101, 3, 16'b000);
    for (int i = 0; i < 3; i++) begin
      shift(i[0], 1'b0);
      chk("t4_gap_out", b1.out, 0);
      chk("t4_gap_state", b1.state, 3);
    end
    run_bits("t4_post", 16'b01, 2, 16'b01);
    chk("t4_cnt", b1.match_cnt, 1);

    // async reset mid-cycle, together with a load of 11
    run_bits("t5_pre", 16'b1010, 4, 16'b0000);
    chk("t5_pre_state", b1.state, 5);
    chk("t5_pre_cnt", b1.match_cnt, 1);
    b1.load = 1'b1; b1.pattern = 8'h03; b1.pat_len = 4'd2; b1.overlap = 1'b1;
    b1.in_valid = 1'b1; b1.in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out", b1.out, 0);
    chk("t5_rst_state", b1.state, 0);
    chk("t5_rst_cnt", b1.match_cnt, 0);
    @(posedge clk); #1;
    b1.load = 1'b0; b1.in_valid = 1'b0;
    rst_n = 1'b1;
    shift(1'b1, 1'b1);
    chk("t5_first_out", b1.out, 0);
    chk("t5_first_state", b1.state, 1);
    chk("t5_first_cnt", b1.match_cnt, 0);
    shift(1'b1, 1'b1);
    chk("t5_second_out", b1.out, 0);
    run_bits("t5_default", 16'b0101, 4, 16'b0001);

    // length 0 clamps to 1, counter saturation on the narrow instance
    do_load(8'h01, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      shift(1'b1, 1'b1);
      chk("t6_out", b1.out, 1);
    end
    chk("t6_cnt8", b1.match_cnt, 5);
    chk("t6_cnt2", b2.match_cnt, 3);
    chk("t6_state", b1.state, 1);

    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_load(8'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(1, 4)),
                1'($urandom_range(0, 1)));
      end else if (r == 3) begin
        b1.in = 1'($urandom_range(0, 1));
        b1.in_valid = 1'($urandom_range(0, 1));
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
      end else begin
        shift(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
